// File: rtl/spi_oled_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_oled_rx_if
// Description : Register-bus bundle for spi_oled_rx. The CPU side drives the
//               request (master), the receiver answers with data and a
//               single-cycle done pulse (slave).
//   ctrl_wr/ctrl_rd : request strobes, held until ctrl_done
//   ctrl_addr       : register byte address
//   ctrl_wdat       : write data
//   ctrl_rdat       : read data, non-zero only while ctrl_done=1
//   ctrl_done       : completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_oled_rx_if;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic [7:0]  ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (
    output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    input  ctrl_rdat, ctrl_done
  );

  modport slave (
    input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    output ctrl_rdat, ctrl_done
  );
endinterface
`default_nettype wire

// File: rtl/spi_oled_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_oled_rx
// Description : SPI peripheral-side receiver. Synchronises MOSI/SCLK/CS/D-C
//               into clk, deserialises bytes MSB-first, tags each with D/C,
//               queues {dc,byte} in a FIFO and exposes it on a register bus.
//   clk, resetn : system clock, synchronous active-low reset
//   bus         : register bus (slave side of spi_oled_rx_if)
//   spi_*       : asynchronous link lines from the master
//   irq         : high while the FIFO holds at least one entry
// Registers   : 0x00 STATUS, 0x04 DATA (pop), 0x08 MODE, 0x0C BCNT
// Revision    : 1.0 - initial release
// ============================================================================
module spi_oled_rx #(
  parameter int FIFO_DEPTH   = 16,
  parameter int DEFAULT_CPOL = 1,
  parameter int DEFAULT_CPHA = 1
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  spi_oled_rx_if.slave    bus,
  input  wire logic       spi_sclk,
  input  wire logic       spi_mosi,
  input  wire logic       spi_cs,
  input  wire logic       spi_dc,
  output logic            irq
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic       c_RST_CPOL = 1'(DEFAULT_CPOL);
  localparam logic       c_RST_CPHA = 1'(DEFAULT_CPHA);
  localparam logic [7:0] c_A_STATUS = 8'h00;
  localparam logic [7:0] c_A_DATA   = 8'h04;
  localparam logic [7:0] c_A_MODE   = 8'h08;
  localparam logic [7:0] c_A_BCNT   = 8'h0C;

  // --------------------------------------------------------------------------
  // Synchronisers. sclk_q[1] is the synchronised level, sclk_q[2] its delayed
  // copy for edge detection.
  // --------------------------------------------------------------------------
  logic [2:0] sclk_q;
  logic [1:0] cs_q, mosi_q, dc_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_q <= {3{c_RST_CPOL}};
      cs_q   <= 2'b11;
      mosi_q <= 2'b00;
      dc_q   <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q   <= {cs_q[0], spi_cs};
      mosi_q <= {mosi_q[0], spi_mosi};
      dc_q   <= {dc_q[0], spi_dc};
    end
  end

  logic w_cs, w_mosi, w_dc, w_rise, w_fall, w_sample;
  logic [1:0] mode_q, mode_d;

  assign w_cs     = cs_q[1];
  assign w_mosi   = mosi_q[1];
  assign w_dc     = dc_q[1];
  assign w_rise   = sclk_q[1] & ~sclk_q[2];
  assign w_fall   = ~sclk_q[1] & sclk_q[2];
  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling.
  assign w_sample = (mode_q[1] == mode_q[0]) ? w_rise : w_fall;

  // --------------------------------------------------------------------------
  // Register bus decode
  // --------------------------------------------------------------------------
  logic        done_q, done_d;
  logic [31:0] rdat_q, rdat_d;
  logic        w_accept, w_wr, w_rd;
  logic        w_stat_wr, w_mode_wr, w_bcnt_wr;

  assign w_accept  = (bus.ctrl_wr | bus.ctrl_rd) & ~done_q;
  assign w_wr      = w_accept & bus.ctrl_wr;
  // A combined wr+rd request is treated as a write; the read side is void.
  assign w_rd      = w_accept & bus.ctrl_rd & ~bus.ctrl_wr;
  assign w_stat_wr = w_wr && (bus.ctrl_addr == c_A_STATUS);
  assign w_mode_wr = w_wr && (bus.ctrl_addr == c_A_MODE);
  assign w_bcnt_wr = w_wr && (bus.ctrl_addr == c_A_BCNT);

  // --------------------------------------------------------------------------
  // Deserialiser
  // --------------------------------------------------------------------------
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       w_push, w_ferr_set;
  logic [8:0] w_push_data;

  assign w_push_data = {w_dc, shift_q[6:0], w_mosi};

  always_comb begin
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    w_push     = 1'b0;
    // Deselect with a partially assembled byte is a framing error.
    w_ferr_set = w_cs && (bitcnt_q != 3'd0);
    if (w_mode_wr || w_cs) begin
      bitcnt_d = 3'd0;
      shift_d  = 8'h00;
    end else if (w_sample) begin
      shift_d  = {shift_q[6:0], w_mosi};
      bitcnt_d = bitcnt_q + 3'd1;
      w_push   = (bitcnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
    end else begin
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          w_full, w_ne, w_pop, w_push_ok, w_ovf_set;
  logic [8:0]    w_fill;

  assign w_full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign w_ne      = (count_q != '0);
  assign w_fill    = 9'(count_q);
  assign w_pop     = w_rd && (bus.ctrl_addr == c_A_DATA) && w_ne;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_comb begin
    wr_ptr_d = w_push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (w_push_ok && !w_pop)      count_d = count_q + (AW+1)'(1);
    else if (w_pop && !w_push_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq      <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq      <= (count_d != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Status flags, mode and byte counter
  // --------------------------------------------------------------------------
  logic        ovf_q, ovf_d, ferr_q, ferr_d;
  logic [15:0] bcnt_q, bcnt_d;

  always_comb begin
    // Set has priority over a same-cycle write-1-to-clear.
    ovf_d  = w_ovf_set  | (ovf_q  & ~(w_stat_wr & bus.ctrl_wdat[2]));
    ferr_d = w_ferr_set | (ferr_q & ~(w_stat_wr & bus.ctrl_wdat[3]));
    mode_d = w_mode_wr ? bus.ctrl_wdat[1:0] : mode_q;
    if (w_bcnt_wr)      bcnt_d = 16'h0000;
    else if (w_push_ok) bcnt_d = bcnt_q + 16'h0001;
    else                bcnt_d = bcnt_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
      mode_q <= {c_RST_CPOL, c_RST_CPHA};
      bcnt_q <= 16'h0000;
    end else begin
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
      mode_q <= mode_d;
      bcnt_q <= bcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux; read data is registered alongside the done pulse.
  // --------------------------------------------------------------------------
  logic [31:0] w_status;
  assign w_status = {15'b0, w_fill, 3'b0, w_cs, ferr_q, ovf_q, w_full, w_ne};

  always_comb begin
    done_d = w_accept;
    rdat_d = 32'h0;
    if (w_rd) begin
      case (bus.ctrl_addr)
        c_A_STATUS: rdat_d = w_status;
        c_A_DATA:   rdat_d = w_ne ? {22'b0, 1'b1, mem_q[rd_ptr_q]} : 32'h0;
        c_A_MODE:   rdat_d = {30'b0, mode_q};
        c_A_BCNT:   rdat_d = {16'b0, bcnt_q};
        default:    rdat_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      done_q <= 1'b0;
      rdat_q <= 32'h0;
    end else begin
      done_q <= done_d;
      rdat_q <= rdat_d;
    end
  end

  assign bus.ctrl_done = done_q;
  assign bus.ctrl_rdat = rdat_q;

  logic w_unused;
  assign w_unused = &{1'b0, bus.ctrl_wdat[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_spi_oled_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_oled_rx
// Description : Self-checking bench for spi_oled_rx. An SPI master model
//               drives the link in all four modes; a queue-based model of the
//               receiver's FIFO, flags and byte counter supplies expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_oled_rx;

  localparam int DEPTH = 16;
  localparam int H     = 40;   // SCLK half period: 4 clk

  logic clk = 1'b0;
  logic resetn;
  logic spi_sclk, spi_mosi, spi_cs, spi_dc;
  logic irq;

  always #5 clk = ~clk;

  spi_oled_rx_if bus ();

  spi_oled_rx #(
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_CPOL(1),
    .DEFAULT_CPHA(1)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_cs  (spi_cs),
    .spi_dc  (spi_dc),
    .irq     (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0]  q[$];
  logic        m_ovf, m_ferr;
  logic [15:0] m_bcnt;
  logic        cpol, cpha;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [8:0] fill;
    fill = 9'(q.size());
    return {15'b0, fill, 3'b0, 1'b1, m_ferr, m_ovf,
            (q.size() == DEPTH), (q.size() != 0)};
  endfunction

  function automatic void model_push(input logic dc, input logic [7:0] b);
    if (q.size() < DEPTH) begin
      q.push_back({dc, b});
      m_bcnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  // One bus access, held until done; a missing done counts as a failure.
  task automatic bus_xfer(input logic wr, input logic rd, input logic [7:0] addr,
                          input logic [31:0] wdat, output logic [31:0] rdat);
    logic seen;
    seen = 1'b0;
    rdat = 32'h0;
    @(negedge clk);
    bus.ctrl_wr = wr; bus.ctrl_rd = rd; bus.ctrl_addr = addr; bus.ctrl_wdat = wdat;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.ctrl_done) begin
        seen = 1'b1;
        rdat = bus.ctrl_rdat;
      end
    end
    bus.ctrl_wr = 1'b0; bus.ctrl_rd = 1'b0;
    check("bus_done", {31'b0, seen}, 32'h1);
  endtask

  task automatic rd_reg(input logic [7:0] addr, output logic [31:0] d);
    bus_xfer(1'b0, 1'b1, addr, 32'h0, d);
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, 1'b0, addr, d, dummy);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    rd_reg(8'h00, d);
    check(tag, d, exp_status());
  endtask

  task automatic check_pop(input string tag);
    logic [31:0] d, e;
    e = 32'h0;
    if (q.size() != 0) e = {22'b0, 1'b1, q.pop_front()};
    rd_reg(8'h04, d);
    check(tag, d, e);
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    wr_reg(8'h08, {30'b0, pol, pha});
    cpol = pol; cpha = pha;
    spi_sclk = pol;
    #(H);
  endtask

  // SPI master
  task automatic spi_bit(input logic b);
    if (!cpha) begin
      spi_mosi = b; #(H); spi_sclk = ~spi_sclk; #(H); spi_sclk = ~spi_sclk;
    end else begin
      spi_sclk = ~spi_sclk; spi_mosi = b; #(H); spi_sclk = ~spi_sclk; #(H);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic dc);
    spi_dc = dc;
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0; #(H);
  endtask

  task automatic cs_high();
    #(H); spi_cs = 1'b1; #(60);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic        dc, seen;
    int          n;

    resetn = 1'b0;
    bus.ctrl_wr = 1'b0; bus.ctrl_rd = 1'b0; bus.ctrl_addr = 8'h0; bus.ctrl_wdat = 32'h0;
    spi_sclk = 1'b1; spi_mosi = 1'b0; spi_cs = 1'b1; spi_dc = 1'b0;
    m_ovf = 1'b0; m_ferr = 1'b0; m_bcnt = 16'h0; cpol = 1'b1; cpha = 1'b1;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_done", {31'b0, bus.ctrl_done}, 32'h0);
    check("rst_rdat", bus.ctrl_rdat, 32'h0);
    rd_reg(8'h00, d); check("rst_status", d, 32'h0000_0010);
    rd_reg(8'h08, d); check("rst_mode", d, 32'h0000_0003);

    // Mode 3, two-byte frame
    cs_low();
    spi_byte(8'hA5, 1'b1); model_push(1'b1, 8'hA5);
    spi_byte(8'h3C, 1'b0); model_push(1'b0, 8'h3C);
    cs_high();
    check("m3_irq", {31'b0, irq}, 32'h1);
    check_status("m3_status");
    check_pop("m3_data0");
    check_pop("m3_data1");
    check_pop("m3_empty");
    check("m3_irq_clr", {31'b0, irq}, 32'h0);
    rd_reg(8'h0C, d); check("m3_bcnt", d, {16'b0, m_bcnt});

    // Mode 0 and mode 1
    set_mode(1'b0, 1'b0);
    cs_low(); spi_byte(8'h81, 1'b0); model_push(1'b0, 8'h81); cs_high();
    check_pop("m0_data");
    set_mode(1'b0, 1'b1);
    cs_low(); spi_byte(8'h81, 1'b0); model_push(1'b0, 8'h81); cs_high();
    check_pop("m1_data");

    // Framing error on a 5-bit frame, then W1C and recovery
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)));
    cs_high();
    m_ferr = 1'b1;
    check_status("ferr_set");
    wr_reg(8'h00, 32'h8); m_ferr = 1'b0;
    check_status("ferr_clr");
    cs_low(); spi_byte(8'h55, 1'b0); model_push(1'b0, 8'h55); cs_high();
    check_pop("ferr_recover");

    // MODE write discards a partial byte without FERR
    cs_low();
    for (int i = 0; i < 3; i++) spi_bit(1'b1);
    wr_reg(8'h08, {30'b0, cpol, cpha});
    cs_high();
    check_status("mode_discard");

    // Overflow: 17 bytes into a 16-deep FIFO
    wr_reg(8'h0C, 32'h0); m_bcnt = 16'h0;
    rd_reg(8'h0C, d); check("bcnt_clr", d, 32'h0);
    cs_low();
    for (int i = 0; i <= DEPTH; i++) begin
      spi_byte(8'(i), 1'b0); model_push(1'b0, 8'(i));
    end
    cs_high();
    check_status("ovf_status");
    rd_reg(8'h0C, d); check("ovf_bcnt", d, {16'b0, m_bcnt});
    for (int i = 0; i < DEPTH; i++) check_pop($sformatf("ovf_pop%0d", i));
    check_pop("ovf_empty");
    wr_reg(8'h00, 32'h4); m_ovf = 1'b0;
    check_status("ovf_clr");

    // Pop in the same cycle as a push into a full FIFO
    cs_low();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom); dc = 1'($urandom_range(0, 1));
      spi_byte(b, dc); model_push(dc, b);
    end
    b = 8'hC3;
    seen = 1'b0;
    fork
      spi_byte(b, 1'b1);
      begin
        // The receiver's push strobe is used only to align the read request.
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (dut.w_push) seen = 1'b1;
        end
        bus.ctrl_addr = 8'h04; bus.ctrl_rd = 1'b1;
        @(posedge clk); #1;
        check("simul_done", {31'b0, bus.ctrl_done}, 32'h1);
        check("simul_data", bus.ctrl_rdat, {22'b0, 1'b1, q[0]});
        bus.ctrl_rd = 1'b0;
      end
    join
    check("simul_align", {31'b0, seen}, 32'h1);
    void'(q.pop_front());
    model_push(1'b1, b);
    cs_high();
    check_status("simul_status");
    while (q.size() != 0) check_pop("simul_drain");

    // Randomised frames in random modes
    for (int r = 0; r < 4; r++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 5);
      cs_low();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom); dc = 1'($urandom_range(0, 1));
        spi_byte(b, dc); model_push(dc, b);
      end
      cs_high();
      check_status($sformatf("rnd%0d_status", r));
      for (int i = 0; i < n; i++) check_pop($sformatf("rnd%0d_pop%0d", r, i));
    end
    rd_reg(8'h0C, d); check("rnd_bcnt", d, {16'b0, m_bcnt});

    // Combined wr+rd, unmapped address, ignored DATA write
    bus_xfer(1'b1, 1'b1, 8'h08, 32'h2, d);
    check("wrrd_rdat", d, 32'h0);
    rd_reg(8'h08, d); check("wrrd_mode", d, 32'h2);
    rd_reg(8'h10, d); check("unmapped_rd", d, 32'h0);
    cpol = 1'b1; cpha = 1'b0; spi_sclk = 1'b1; #(H);
    cs_low(); spi_byte(8'h96, 1'b1); model_push(1'b1, 8'h96); cs_high();
    wr_reg(8'h04, 32'hFFFF_FFFF);
    wr_reg(8'h20, 32'hFFFF_FFFF);
    check_status("data_wr_ignored");
    check_pop("m2_data");
    @(posedge clk); #1;
    check("idle_rdat", bus.ctrl_rdat, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/spi_oled_rx.md
Name: spi_oled_rx

Overview:
- SPI peripheral-side receiver: the far end of the OLED SPI link (MOSI, SCLK, CS, D/C).
- Samples the four link lines in the clk domain and deserialises bytes MSB-first.
- Tags each byte with the D/C level, queues it in a FIFO, and exposes it to the CPU over the ctrl_* register bus.
- Used as a loopback/monitor target for OLED driver bring-up, and as a generic SPI peripheral for external masters.

Parameters:
- FIFO_DEPTH, 16, number of {dc,byte} entries; power of two, 2..256.
- DEFAULT_CPOL, 1, reset value of MODE.cpol.
- DEFAULT_CPHA, 1, reset value of MODE.cpha.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- ctrl_wr  in  1  register write request; held until ctrl_done.
- ctrl_rd  in  1  register read request; held until ctrl_done.
- ctrl_addr  in  8  register byte address.
- ctrl_wdat  in  32  write data.
- ctrl_rdat  out  32  read data; valid only while ctrl_done=1, 0 otherwise.
- ctrl_done  out  1  single-cycle completion pulse.
- spi_sclk  in  1  serial clock from the master (async).
- spi_mosi  in  1  serial data (async).
- spi_cs  in  1  chip select, active low (async).
- spi_dc  in  1  data/command flag (async).
- irq  out  1  high while the FIFO is non-empty.

Behaviour:

Reset (resetn=0 at posedge clk):
- FIFO empty; bit counter and shift register 0; OVF, FERR and BCNT cleared; MODE={DEFAULT_CPOL,DEFAULT_CPHA}.
- ctrl_done=0, ctrl_rdat=0, irq=0; synchronisers load idle levels (sclk=DEFAULT_CPOL, cs=1, mosi=0, dc=0).

Input sampling and framing:
- Each SPI input passes through a 2-FF synchroniser, plus one extra flop on sclk for edge detect.
- SCLK high and low phases must each be at least 2 clk periods.
- Sample edge is the rising synchronised sclk edge when cpol==cpha, otherwise the falling edge.
- While synced cs=1: bit counter held at 0 and shift register cleared.
- Synced cs 1->0 starts a frame.
- On each sample edge with cs=0: shift_reg <= {shift_reg[6:0], mosi}; bit counter increments.
- On the 8th bit, push {dc, byte}, where dc is the synced level at that same edge. The counter wraps to 0 and the frame continues; multi-byte frames are allowed.
- cs 0->1 with bit counter !=0: partial byte discarded and FERR set (sticky).
- Push latency: the entry is visible in STATUS/irq within 4 clk of the 8th sample edge at the pins.

FIFO:
- Push when full: entry dropped and OVF set (sticky). Exception: a pop in the same cycle frees the slot first, so the push is accepted.
- Simultaneous push and pop on a non-full FIFO: both occur, count unchanged.
- Pointers are log2(FIFO_DEPTH) bits, natural wrap.

Register bus:
- A request is accepted in a cycle where ctrl_wr|ctrl_rd=1 and ctrl_done=0.
- ctrl_done pulses on the following cycle. No request is accepted while ctrl_done=1, so a held request causes exactly one access.
- If wr and rd are asserted together, the write is performed and the read returns 0.
- 0x00 STATUS (R):
  - bit0 not_empty, bit1 full, bit2 OVF, bit3 FERR, bit4 synced cs, bits[16:8] fill count.
  - Writes are write-1-to-clear on bits 2 and 3.
  - If an event sets a flag in the same cycle it is cleared, the set wins.
- 0x04 DATA (R):
  - Non-empty: returns {22'b0, valid=1 at bit9, dc at bit8, byte[7:0]} and pops.
  - Empty: returns 0 and pops nothing.
  - Writes are ignored but still complete.
- 0x08 MODE (R/W):
  - bit1 cpol, bit0 cpha.
  - A write also resets bit counter and shift register; a partial byte is discarded without setting FERR.
- 0x0C BCNT (R): 16-bit count of bytes pushed successfully; wraps 0xFFFF->0. Any write clears it; clear wins over a same-cycle increment.
- Unmapped addresses: reads return 0; writes have no effect; both complete in 1 cycle.

irq:
- irq = not_empty, registered; updates in the same cycle as the FIFO state.

Test Plan:
- Reset, then read STATUS and MODE -> STATUS=0x00000010 (cs idle high), MODE=0x3, irq=0.
- Mode 3, master sends 0xA5 with dc=1 then 0x3C with dc=0 in one CS frame -> irq=1, STATUS count=2; DATA reads 0x000003A5 then 0x0000023C; third read returns 0; irq=0; BCNT=2.
- Write MODE=0x0 (mode 0), send 0x81 with sclk idle low, sampling on rising edge -> DATA=0x00000281. Repeat in mode 1 (MODE=0x1, falling-edge sampling) -> same result.
- Send 5 bits then raise CS -> no push, STATUS.FERR=1. Write STATUS=0x8 -> FERR=0. Next full byte 0x55 is received correctly (DATA=0x255).
- FIFO_DEPTH=16: send 17 bytes 0x00..0x10 without reading -> full=1, OVF=1, BCNT=16. Reads return 0x00..0x0F in order; 0x10 is lost.
- Fill FIFO, then pop DATA in the same cycle as the 17th byte's push -> push accepted, OVF stays 0, count stays 16.
